tl_mem_responder: RTL and testbench

TileLink responder fronting a single-ported 64-bit synchronous SRAM; the memory-side end of the channel driven by the core's load/store/AMO data agent. Serves Get, PutFullData, ArithmeticData and LogicalData one transaction at a time. Executes atomics as internal read-modify-write and implements LR/SC reservation via `a_corrupt`. Returns lane-aligned data so the agent's shift/sign-extend path works unchanged.

---
 rtl/tl_mem_responder.sv | 247 ++++++++++++++++++++++++
 tb/tb_tl_mem_responder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_mem_responder.sv
// TileLink responder in front of a single-ported 64-bit synchronous SRAM.
// Serves Get/PutFull/Arithmetic/Logical one at a time; LR/SC is signalled on a_corrupt.
module tl_mem_responder #(
    parameter int MEM_AW = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [2:0]        a_opcode,
    input  logic [2:0]        a_param,
    input  logic [2:0]        a_size,
    input  logic [7:0]        a_source,
    input  logic [31:0]       a_address,
    input  logic [7:0]        a_mask,
    input  logic [63:0]       a_data,
    input  logic              a_corrupt,
    output logic              d_valid,
    input  logic              d_ready,
    output logic [2:0]        d_opcode,
    output logic [1:0]        d_param,
    output logic [2:0]        d_size,
    output logic [7:0]        d_source,
    output logic [63:0]       d_data,
    output logic              d_denied,
    output logic              d_corrupt,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [7:0]        mem_wmask,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdata
);

    localparam logic [2:0] TL_PUT_FULL    = 3'd0;
    localparam logic [2:0] TL_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] TL_ARITH       = 3'd2;
    localparam logic [2:0] TL_LOGIC       = 3'd3;
    localparam logic [2:0] TL_GET         = 3'd4;
    localparam logic [2:0] TL_ACK         = 3'd0;
    localparam logic [2:0] TL_ACK_DATA    = 3'd1;

    localparam logic [2:0] TL_MIN  = 3'd0;
    localparam logic [2:0] TL_MAX  = 3'd1;
    localparam logic [2:0] TL_MINU = 3'd2;
    localparam logic [2:0] TL_MAXU = 3'd3;
    localparam logic [2:0] TL_XOR  = 3'd0;
    localparam logic [2:0] TL_OR   = 3'd1;
    localparam logic [2:0] TL_AND  = 3'd2;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_CAP  = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    logic [2:0]        state;
    logic [2:0]        op_q;
    logic [2:0]        param_q;
    logic [2:0]        size_q;
    logic [2:0]        off_q;
    logic [MEM_AW-1:0] idx_q;
    logic [63:0]       opnd_q;
    logic [7:0]        lanes_q;
    logic [63:0]       wdata_q;
    logic              resv_valid;
    logic [MEM_AW-1:0] resv_idx;

    logic [MEM_AW-1:0] a_idx;
    logic [7:0]        lane_base;
    logic [7:0]        a_lanes;
    logic              misalign;
    logic              out_of_range;
    logic              bad_op;
    logic              is_amo;
    logic              deny;
    logic              resv_hit;
    logic              unused_mask;

    assign a_idx        = a_address[MEM_AW+2:3];
    assign out_of_range = (a_address >> (MEM_AW + 3)) != 32'd0;
    assign is_amo       = (a_opcode == TL_ARITH) || (a_opcode == TL_LOGIC);
    assign resv_hit     = resv_valid && (resv_idx == a_idx);
    assign a_lanes      = lane_base << a_address[2:0];
    assign unused_mask  = ^a_mask;

    // Sizes above a dword cannot be placed on the 64-bit lanes, so they are treated as misaligned.
    always_comb begin
        lane_base = 8'hFF;
        misalign  = 1'b1;
        case (a_size)
            3'd0: begin lane_base = 8'h01; misalign = 1'b0;            end
            3'd1: begin lane_base = 8'h03; misalign = a_address[0];    end
            3'd2: begin lane_base = 8'h0F; misalign = |a_address[1:0]; end
            3'd3: begin lane_base = 8'hFF; misalign = |a_address[2:0]; end
            default: ;
        endcase
    end

    always_comb begin
        case (a_opcode)
            TL_GET, TL_PUT_FULL: bad_op = 1'b0;
            TL_ARITH:            bad_op = a_param > 3'd4;
            TL_LOGIC:            bad_op = a_param > 3'd3;
            default:             bad_op = 1'b1;
        endcase
    end

    assign deny = out_of_range || misalign || bad_op || (is_amo && (a_size < 3'd2));

    logic [31:0] old32;
    logic [63:0] a_u, a_s, b_u, b_s;
    logic        lt_s, lt_u;
    logic [63:0] amo_res;
    logic [63:0] amo_wdata;

    // Word operands are extended to 64 bits so one comparator/adder serves both sizes.
    always_comb begin
        old32 = off_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];
        if (size_q == 3'd3) begin
            a_u = mem_rdata;
            a_s = mem_rdata;
            b_u = opnd_q;
            b_s = opnd_q;
        end else begin
            a_u = {32'd0, old32};
            a_s = {{32{old32[31]}}, old32};
            b_u = {32'd0, opnd_q[31:0]};
            b_s = {{32{opnd_q[31]}}, opnd_q[31:0]};
        end
        lt_s    = $signed(a_s) < $signed(b_s);
        lt_u    = a_u < b_u;
        amo_res = b_u;
        if (op_q == TL_ARITH) begin
            case (param_q)
                TL_MIN:  amo_res = lt_s ? a_u : b_u;
                TL_MAX:  amo_res = lt_s ? b_u : a_u;
                TL_MINU: amo_res = lt_u ? a_u : b_u;
                TL_MAXU: amo_res = lt_u ? b_u : a_u;
                default: amo_res = a_u + b_u;
            endcase
        end else begin
            case (param_q)
                TL_XOR:  amo_res = a_u ^ b_u;
                TL_OR:   amo_res = a_u | b_u;
                TL_AND:  amo_res = a_u & b_u;
                default: amo_res = b_u;
            endcase
        end
        amo_wdata = (size_q == 3'd3) ? amo_res : {2{amo_res[31:0]}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            op_q       <= '0;
            param_q    <= '0;
            size_q     <= '0;
            off_q      <= '0;
            idx_q      <= '0;
            opnd_q     <= '0;
            lanes_q    <= '0;
            wdata_q    <= '0;
            resv_valid <= 1'b0;
            resv_idx   <= '0;
            d_valid    <= 1'b0;
            d_opcode   <= '0;
            d_param    <= '0;
            d_size     <= '0;
            d_source   <= '0;
            d_data     <= '0;
            d_denied   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (a_valid) begin
                    op_q     <= a_opcode;
                    param_q  <= a_param;
                    size_q   <= a_size;
                    off_q    <= a_address[2:0];
                    idx_q    <= a_idx;
                    opnd_q   <= a_data;
                    lanes_q  <= a_lanes;
                    wdata_q  <= a_data << {a_address[2:0], 3'b000};
                    d_size   <= a_size;
                    d_source <= a_source;
                    d_opcode <= (((a_opcode == TL_PUT_FULL) && !a_corrupt) || (a_opcode == TL_PUT_PARTIAL))
                                ? TL_ACK : TL_ACK_DATA;
                    d_param  <= 2'd0;
                    d_denied <= deny;
                    d_data   <= '0;
                    if (deny) begin
                        state   <= S_RESP;
                        d_valid <= 1'b1;
                    end else if (a_opcode == TL_GET) begin
                        state <= S_RD;
                        if (a_corrupt) begin
                            resv_valid <= 1'b1;
                            resv_idx   <= a_idx;
                        end
                    end else if ((a_opcode == TL_PUT_FULL) && a_corrupt) begin
                        d_param    <= 2'd1;
                        resv_valid <= 1'b0;
                        if (resv_hit) begin
                            state <= S_WR;
                        end else begin
                            state   <= S_RESP;
                            d_valid <= 1'b1;
                            d_data  <= 64'd1;
                        end
                    end else begin
                        state <= (a_opcode == TL_PUT_FULL) ? S_WR : S_RD;
                        if (resv_hit) resv_valid <= 1'b0;
                    end
                end
                S_RD: state <= S_CAP;
                S_CAP: begin
                    d_data <= mem_rdata;
                    if (op_q == TL_GET) begin
                        state   <= S_RESP;
                        d_valid <= 1'b1;
                    end else begin
                        wdata_q <= amo_wdata;
                        state   <= S_WR;
                    end
                end
                S_WR: begin
                    state   <= S_RESP;
                    d_valid <= 1'b1;
                end
                S_RESP: if (d_ready) begin
                    state   <= S_IDLE;
                    d_valid <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign a_ready   = (state == S_IDLE);
    assign mem_rd    = (state == S_RD);
    assign mem_wr    = (state == S_WR);
    assign mem_wmask = mem_wr ? lanes_q : 8'h00;
    assign mem_wdata = wdata_q;
    assign mem_addr  = idx_q;
    assign d_corrupt = 1'b0;

endmodule

// File: tb/tb_tl_mem_responder.sv
// Bench for tl_mem_responder: table of requests with expected D responses and SRAM traffic,
// plus a reset-during-AMO sequence. A small behavioural SRAM sits on the mem_* port.
module tb_tl_mem_responder;

    localparam int MEM_AW = 12;

    localparam logic [2:0] PUT = 3'd0, ARITH = 3'd2, LOGIC = 3'd3, GET = 3'd4, BADOP = 3'd5;
    localparam logic [2:0] P0 = 3'd0;
    localparam logic [2:0] P_MIN = 3'd0, P_MAX = 3'd1, P_MINU = 3'd2, P_MAXU = 3'd3, P_ADD = 3'd4;
    localparam logic [2:0] P_XOR = 3'd0, P_OR = 3'd1, P_AND = 3'd2, P_SWAP = 3'd3;
    localparam logic [2:0] ACK = 3'd0, ACKD = 3'd1;
    localparam logic [63:0] Z = 64'd0;

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  param;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [63:0] data;
        logic        cor;
        int          lat;
        logic [2:0]  dop;
        logic [1:0]  dpar;
        logic [63:0] ddata;
        logic        den;
        int          nrd;
        int          nwr;
        logic [7:0]  wmask;
        logic [63:0] wdata;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              a_valid, a_ready, a_corrupt;
    logic [2:0]        a_opcode, a_param, a_size;
    logic [7:0]        a_source, a_mask;
    logic [31:0]       a_address;
    logic [63:0]       a_data;
    logic              d_valid, d_ready, d_denied, d_corrupt;
    logic [2:0]        d_opcode, d_size;
    logic [1:0]        d_param;
    logic [7:0]        d_source;
    logic [63:0]       d_data;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_rd, mem_wr;
    logic [7:0]        mem_wmask;
    logic [63:0]       mem_wdata;
    logic [63:0]       mem_rdata = 64'd0;

    logic [63:0] sram [int unsigned];
    int unsigned rd_cnt = 0;
    int unsigned wr_cnt = 0;
    logic [7:0]  last_wmask = 8'h00;
    logic [63:0] last_wdata = 64'd0;

    int   n_pass = 0;
    int   n_checks = 0;
    vec_t exp_q[$];
    vec_t vecs[$];

    tl_mem_responder #(.MEM_AW(MEM_AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
        .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
        .a_data(a_data), .a_corrupt(a_corrupt),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
        .d_size(d_size), .d_source(d_source), .d_data(d_data), .d_denied(d_denied),
        .d_corrupt(d_corrupt),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        logic [63:0] w;
        w = sram.exists(32'(mem_addr)) ? sram[32'(mem_addr)] : 64'd0;
        if (mem_rd) begin
            mem_rdata <= w;
            rd_cnt    <= rd_cnt + 1;
        end
        if (mem_wr) begin
            for (int b = 0; b < 8; b++)
                if (mem_wmask[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
            sram[32'(mem_addr)] = w;
            wr_cnt     <= wr_cnt + 1;
            last_wmask <= mem_wmask;
            last_wdata <= mem_wdata;
        end
    end

    function automatic vec_t mk(logic [2:0] op, logic [2:0] param, logic [2:0] size,
                                logic [31:0] addr, logic [63:0] data, logic cor, int lat,
                                logic [2:0] dop, logic [1:0] dpar, logic [63:0] ddata,
                                logic den, int nrd, int nwr, logic [7:0] wmask,
                                logic [63:0] wdata);
        vec_t v;
        v.op = op; v.param = param; v.size = size; v.addr = addr; v.data = data; v.cor = cor;
        v.lat = lat; v.dop = dop; v.dpar = dpar; v.ddata = ddata; v.den = den;
        v.nrd = nrd; v.nwr = nwr; v.wmask = wmask; v.wdata = wdata;
        return v;
    endfunction

    function automatic logic [63:0] bytes(logic [7:0] m);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) r[8*b +: 8] = {8{m[b]}};
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, expv);
    endtask

    // Entered and left at a falling edge, so consecutive calls issue back-to-back requests.
    task automatic run_vec(input vec_t v, input int idx);
        vec_t        e;
        int          lat;
        logic        ar_bad;
        logic [7:0]  src;
        int unsigned rd0, wr0;
        string       t;
        t   = $sformatf("v%0d", idx);
        src = 8'(idx) ^ 8'h5A;
        exp_q.push_back(v);
        chk({t, " a_ready_idle"}, 64'(a_ready), 64'd1);
        a_valid = 1'b1; a_opcode = v.op; a_param = v.param; a_size = v.size;
        a_address = v.addr; a_data = v.data; a_corrupt = v.cor; a_source = src;
        a_mask = 8'(idx * 37); d_ready = 1'b0;
        rd0 = rd_cnt; wr0 = wr_cnt; lat = 0; ar_bad = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (d_valid) begin lat = k; break; end
            if (a_ready) ar_bad = 1'b1;
        end
        e = exp_q.pop_front();
        chk({t, " latency"}, 64'(lat), 64'(e.lat));
        chk({t, " a_ready_busy"}, 64'(ar_bad | a_ready), 64'd0);
        chk({t, " d_opcode"}, 64'(d_opcode), 64'(e.dop));
        chk({t, " d_param"}, 64'(d_param), 64'(e.dpar));
        chk({t, " d_data"}, d_data, e.ddata);
        chk({t, " d_denied"}, 64'(d_denied), 64'(e.den));
        chk({t, " d_size_src"}, 64'({d_size, d_source, d_corrupt}), 64'({e.size, src, 1'b0}));
        if (idx % 3 == 0) begin
            repeat (2) @(posedge clk);
            #1;
            chk({t, " d_hold"}, {d_data[62:0], d_valid}, {e.ddata[62:0], 1'b1});
        end
        @(negedge clk); d_ready = 1'b1;
        @(posedge clk); #1;
        chk({t, " after_handshake"}, 64'({d_valid, a_ready}), 64'(2'b01));
        chk({t, " rd_count"}, 64'(rd_cnt - rd0), 64'(e.nrd));
        chk({t, " wr_count"}, 64'(wr_cnt - wr0), 64'(e.nwr));
        if (e.nwr > 0) begin
            chk({t, " wmask"}, 64'(last_wmask), 64'(e.wmask));
            chk({t, " wdata"}, last_wdata & bytes(last_wmask), e.wdata);
        end
        @(negedge clk); d_ready = 1'b0; a_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        dv_seen;
        int unsigned wr0;
        rst_n = 1'b1; a_valid = 1'b0; d_ready = 1'b0; a_opcode = 3'd0; a_param = 3'd0;
        a_size = 3'd0; a_source = 8'd0; a_address = 32'd0; a_mask = 8'd0; a_data = 64'd0;
        a_corrupt = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset a_ready", 64'(a_ready), 64'd1);
        chk("reset d_valid", 64'(d_valid), 64'd0);
        chk("reset strobes", 64'({mem_rd, mem_wr, mem_wmask}), 64'd0);
        chk("reset d_fields", d_data | 64'({d_opcode, d_param, d_size, d_source, d_denied}), 64'd0);
        chk("reset mem_addr", 64'(mem_addr), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        //         op     param   sz addr        data                    c     lat dop  dp    ddata                   den   rd wr mask   wdata
        vecs.push_back(mk(PUT,   P0,     3'd3, 32'h10, 64'h1122334455667788, 1'b0, 2, ACK,  2'd0, Z, 1'b0, 0, 1, 8'hFF, 64'h1122334455667788));
        vecs.push_back(mk(GET,   P0,     3'd3, 32'h10, Z, 1'b0, 3, ACKD, 2'd0, 64'h1122334455667788, 1'b0, 1, 0, 8'h00, Z));
        vecs.push_back(mk(PUT,   P0,     3'd0, 32'h13, 64'hAB, 1'b0, 2, ACK, 2'd0, Z, 1'b0, 0, 1, 8'h08, 64'h00000000AB000000));
        vecs.push_back(mk(GET,   P0,     3'd3, 32'h10, Z, 1'b0, 3, ACKD, 2'd0, 64'h11223344AB667788, 1'b0, 1, 0, 8'h00, Z));
        vecs.push_back(mk(PUT,   P0,     3'd1, 32'h16, 64'hBEEF, 1'b0, 2, ACK, 2'd0, Z, 1'b0, 0, 1, 8'hC0, 64'hBEEF000000000000));
        vecs.push_back(mk(GET,   P0,     3'd1, 32'h12, Z, 1'b0, 3, ACKD, 2'd0, 64'hBEEF3344AB667788, 1'b0, 1, 0, 8'h00, Z));
        vecs.push_back(mk(PUT,   P0,     3'd2, 32'h24, 64'hFFFFFFFE, 1'b0, 2, ACK, 2'd0, Z, 1'b0, 0, 1, 8'hF0, 64'hFFFFFFFE00000000));
        vecs.push_back(mk(ARITH, P_ADD,  3'd2, 32'h24, 64'd3, 1'b0, 4, ACKD, 2'd0, 64'hFFFFFFFE00000000, 1'b0, 1, 1, 8'hF0, 64'h0000000100000000));
        vecs.push_back(mk(PUT,   P0,     3'd2, 32'h24, 64'hFFFFFFFE, 1'b0, 2, ACK, 2'd0, Z, 1'b0, 0, 1, 8'hF0, 64'hFFFFFFFE00000000));
        vecs.push_back(mk(ARITH, P_MIN,  3'd2, 32'h24, 64'd5, 1'b0, 4, ACKD, 2'd0, 64'hFFFFFFFE00000000, 1'b0, 1, 1, 8'hF0, 64'hFFFFFFFE00000000));
        vecs.push_back(mk(ARITH, P_MINU, 3'd2, 32'h24, 64'd5, 1'b0, 4, ACKD, 2'd0, 64'hFFFFFFFE00000000, 1'b0, 1, 1, 8'hF0, 64'h0000000500000000));
        vecs.push_back(mk(LOGIC, P_XOR,  3'd3, 32'h20, 64'hFFFF0000FFFF0000, 1'b0, 4, ACKD, 2'd0, 64'h0000000500000000, 1'b0, 1, 1, 8'hFF, 64'hFFFF0005FFFF0000));
        vecs.push_back(mk(ARITH, P_MAXU, 3'd2, 32'h20, 64'h7FFFFFFF, 1'b0, 4, ACKD, 2'd0, 64'hFFFF0005FFFF0000, 1'b0, 1, 1, 8'h0F, 64'h00000000FFFF0000));
        vecs.push_back(mk(ARITH, P_MAX,  3'd2, 32'h20, 64'h7FFFFFFF, 1'b0, 4, ACKD, 2'd0, 64'hFFFF0005FFFF0000, 1'b0, 1, 1, 8'h0F, 64'h000000007FFFFFFF));
        vecs.push_back(mk(LOGIC, P_SWAP, 3'd3, 32'h20, 64'h0123456789ABCDEF, 1'b0, 4, ACKD, 2'd0, 64'hFFFF00057FFFFFFF, 1'b0, 1, 1, 8'hFF, 64'h0123456789ABCDEF));
        vecs.push_back(mk(LOGIC, P_AND,  3'd2, 32'h24, 64'h0000FFFF, 1'b0, 4, ACKD, 2'd0, 64'h0123456789ABCDEF, 1'b0, 1, 1, 8'hF0, 64'h0000456700000000));
        vecs.push_back(mk(LOGIC, P_OR,   3'd3, 32'h20, 64'h1000000000000001, 1'b0, 4, ACKD, 2'd0, 64'h0000456789ABCDEF, 1'b0, 1, 1, 8'hFF, 64'h1000456789ABCDEF));
        vecs.push_back(mk(ARITH, P_ADD,  3'd3, 32'h20, 64'hF000000000000000, 1'b0, 4, ACKD, 2'd0, 64'h1000456789ABCDEF, 1'b0, 1, 1, 8'hFF, 64'h0000456789ABCDEF));
        vecs.push_back(mk(GET,   P0,     3'd3, 32'h20, Z, 1'b0, 3, ACKD, 2'd0, 64'h0000456789ABCDEF, 1'b0, 1, 0, 8'h00, Z));
        // LR/SC
        vecs.push_back(mk(GET,   P0,     3'd3, 32'h40, Z, 1'b1, 3, ACKD, 2'd0, Z, 1'b0, 1, 0, 8'h00, Z));
        vecs.push_back(mk(PUT,   P0,     3'd3, 32'h40, 64'd7, 1'b1, 2, ACKD, 2'd1, Z, 1'b0, 0, 1, 8'hFF, 64'd7));
        vecs.push_back(mk(PUT,   P0,     3'd3, 32'h40, 64'd7, 1'b1, 1, ACKD, 2'd1, 64'd1, 1'b0, 0, 0, 8'h00, Z));
        vecs.push_back(mk(GET,   P0,     3'd3, 32'h40, Z, 1'b1, 3, ACKD, 2'd0, 64'd7, 1'b0, 1, 0, 8'h00, Z));
        vecs.push_back(mk(PUT,   P0,     3'd3, 32'h40, 64'd9, 1'b0, 2, ACK, 2'd0, Z, 1'b0, 0, 1, 8'hFF, 64'd9));
        vecs.push_back(mk(PUT,   P0,     3'd3, 32'h40, 64'hA, 1'b1, 1, ACKD, 2'd1, 64'd1, 1'b0, 0, 0, 8'h00, Z));
        vecs.push_back(mk(GET,   P0,     3'd3, 32'h40, Z, 1'b0, 3, ACKD, 2'd0, 64'd9, 1'b0, 1, 0, 8'h00, Z));
        vecs.push_back(mk(GET,   P0,     3'd3, 32'h40, Z, 1'b1, 3, ACKD, 2'd0, 64'd9, 1'b0, 1, 0, 8'h00, Z));
        vecs.push_back(mk(PUT,   P0,     3'd3, 32'h48, 64'd1, 1'b1, 1, ACKD, 2'd1, 64'd1, 1'b0, 0, 0, 8'h00, Z));
        vecs.push_back(mk(PUT,   P0,     3'd3, 32'h40, 64'd2, 1'b1, 1, ACKD, 2'd1, 64'd1, 1'b0, 0, 0, 8'h00, Z));
        // Denied requests
        vecs.push_back(mk(GET,   P0,     3'd3, 32'h8000, Z, 1'b0, 1, ACKD, 2'd0, Z, 1'b1, 0, 0, 8'h00, Z));
        vecs.push_back(mk(PUT,   P0,     3'd2, 32'h2, 64'h55, 1'b0, 1, ACK, 2'd0, Z, 1'b1, 0, 0, 8'h00, Z));
        vecs.push_back(mk(ARITH, P_ADD,  3'd1, 32'h0, 64'd1, 1'b0, 1, ACKD, 2'd0, Z, 1'b1, 0, 0, 8'h00, Z));
        vecs.push_back(mk(BADOP, P0,     3'd3, 32'h0, Z, 1'b0, 1, ACKD, 2'd0, Z, 1'b1, 0, 0, 8'h00, Z));
        // Denied Put to an alias of the reserved dword leaves the reservation intact
        vecs.push_back(mk(GET,   P0,     3'd3, 32'h40, Z, 1'b1, 3, ACKD, 2'd0, 64'd9, 1'b0, 1, 0, 8'h00, Z));
        vecs.push_back(mk(PUT,   P0,     3'd3, 32'h8040, 64'd1, 1'b0, 1, ACK, 2'd0, Z, 1'b1, 0, 0, 8'h00, Z));
        vecs.push_back(mk(PUT,   P0,     3'd3, 32'h40, 64'h55, 1'b1, 2, ACKD, 2'd1, Z, 1'b0, 0, 1, 8'hFF, 64'h55));
        vecs.push_back(mk(GET,   P0,     3'd3, 32'h40, Z, 1'b0, 3, ACKD, 2'd0, 64'h55, 1'b0, 1, 0, 8'h00, Z));
        vecs.push_back(mk(GET,   P0,     3'd3, 32'h60, Z, 1'b1, 3, ACKD, 2'd0, Z, 1'b0, 1, 0, 8'h00, Z));

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Reset while an AMO to 0x68 sits in CAP; reservation on 0x60 must be lost too.
        wr0 = wr_cnt;
        a_valid = 1'b1; a_opcode = ARITH; a_param = P_ADD; a_size = 3'd3;
        a_address = 32'h68; a_data = 64'd1; a_corrupt = 1'b0; a_source = 8'h33;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0; a_valid = 1'b0;
        #1;
        chk("rst_mid in_reset", 64'({d_valid, a_ready, mem_wr, mem_rd}), 64'(4'b0100));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dv_seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (d_valid || mem_wr) dv_seen = 1'b1;
        end
        chk("rst_mid no_d_or_wr", 64'(dv_seen), 64'd0);
        chk("rst_mid wr_count", 64'(wr_cnt - wr0), 64'd0);
        chk("rst_mid a_ready", 64'(a_ready), 64'd1);
        @(negedge clk);
        run_vec(mk(PUT, P0, 3'd3, 32'h60, 64'd3, 1'b1, 1, ACKD, 2'd1, 64'd1, 1'b0, 0, 0, 8'h00, Z), 100);
        run_vec(mk(GET, P0, 3'd3, 32'h68, Z, 1'b0, 3, ACKD, 2'd0, Z, 1'b0, 1, 0, 8'h00, Z), 101);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
